// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Types and constants shared by the VGA sprite pipeline.
//   H_ACTIVE / V_ACTIVE : visible area of the 1024x768 timing
//   pos_t               : 11-bit pixel coordinate
//   upd_state_t         : position-update FSM states
//   vga_tim_t           : timing bundle (counts, syncs, blanks) without rgb
//   in_span()           : 12-bit window test that cannot wrap at 2048
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int H_ACTIVE = 1024;
  localparam int V_ACTIVE = 768;

  typedef logic [10:0] pos_t;

  typedef enum logic [0:0] {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } upd_state_t;

  typedef struct packed {
    pos_t hcount;
    pos_t vcount;
    logic hsync;
    logic vsync;
    logic hblnk;
    logic vblnk;
  } vga_tim_t;

  // True when base <= p < base+len. Done in 12 bits so a window that starts
  // near 2047 is not folded back onto the low columns.
  function automatic logic in_span(input pos_t p, input pos_t base, input int len);
    logic [11:0] lo;
    logic [11:0] hi;
    lo = {1'b0, base};
    hi = lo + 12'(len);
    return ({1'b0, p} >= lo) && ({1'b0, p} < hi);
  endfunction

endpackage

// File: rtl/vga_if.sv
// -----------------------------------------------------------------------------
// vga_if
// One VGA pixel stream: hcount/vcount (11b), hsync/vsync/hblnk/vblnk, rgb (12b).
//   modport in  : consumer side (all inputs)
//   modport out : producer side (all outputs)
// -----------------------------------------------------------------------------
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
  modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/vga_delay.sv
// -----------------------------------------------------------------------------
// vga_delay
// N-stage register delay of the VGA timing bundle.
//   clk   : pixel clock
//   rst   : asynchronous active-high reset, clears every stage to 0
//   tim_i : timing bundle in
//   tim_o : timing bundle delayed by N clocks
// -----------------------------------------------------------------------------
module vga_delay
  import vga_pkg::*;
#(
  parameter int N = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  vga_tim_t tim_i,
  output vga_tim_t tim_o
);

  vga_tim_t pipe_q [N];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q[0] <= tim_i;
      for (int i = 1; i < N; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign tim_o = pipe_q[N-1];

endmodule

// File: rtl/draw_sprite.sv
// -----------------------------------------------------------------------------
// draw_sprite
// Overlays a WIDTH x HEIGHT sprite, fetched from an external ROM, onto a VGA
// pixel stream. Two-clock pipeline for every field of the bundle.
//   clk        : pixel clock
//   rst        : asynchronous active-high reset
//   vga_in     : incoming pixel stream (vga_if.in)
//   vga_out    : outgoing pixel stream, 2 clocks behind vga_in (vga_if.out)
//   xpos/ypos  : requested sprite top-left corner
//   pos_valid  : one-cycle strobe capturing xpos/ypos (applied at vblank rise)
//   mirror     : horizontal flip, captured with pos_valid (SPRITE_MIRROR_EN only)
//   rom_addr   : registered ROM read address
//   rom_pixel  : ROM data for rom_addr, sampled one clock after the address
// Build option: define SPRITE_MIRROR_EN to add the mirror port.
// -----------------------------------------------------------------------------
module draw_sprite
  import vga_pkg::*;
#(
  parameter int          WIDTH     = 64,
  parameter int          HEIGHT    = 64,
  parameter logic [11:0] KEY_COLOR = 12'hF0F,
  parameter int          INIT_X    = 0,
  parameter int          INIT_Y    = 0,
  parameter int          AW        = $clog2(WIDTH * HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  vga_if.in             vga_in,
  vga_if.out            vga_out,
  input  logic [10:0]   xpos,
  input  logic [10:0]   ypos,
  input  logic          pos_valid,
`ifdef SPRITE_MIRROR_EN
  input  logic          mirror,
`endif
  output logic [AW-1:0] rom_addr,
  input  logic [11:0]   rom_pixel
);

  // ---------------------------------------------------------------------------
  // Timing bundle delay (counts, syncs, blanks)
  // ---------------------------------------------------------------------------
  vga_tim_t tim_in;
  vga_tim_t tim_out;

  assign tim_in = {vga_in.hcount, vga_in.vcount, vga_in.hsync,
                   vga_in.vsync, vga_in.hblnk, vga_in.vblnk};

  vga_delay #(.N(2)) u_delay (
    .clk   (clk),
    .rst   (rst),
    .tim_i (tim_in),
    .tim_o (tim_out)
  );

  // ---------------------------------------------------------------------------
  // Position update FSM: requests are parked until the vblank rising edge
  // ---------------------------------------------------------------------------
  upd_state_t state_q, state_d;
  pos_t       ax_q, ax_d, ay_q, ay_d;     // active position
  pos_t       px_q, px_d, py_q, py_d;     // pending position
  logic       vblnk_q;
  logic       vblnk_rise;
`ifdef SPRITE_MIRROR_EN
  logic       mir_q, mir_d, pmir_q, pmir_d;
`endif

  assign vblnk_rise = vga_in.vblnk & ~vblnk_q;

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: a request coinciding with the vblank rise is applied at
  // once, so it never leaves the FSM in PENDING.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (pos_valid && !vblnk_rise) ? PENDING : IDLE;
      PENDING: state_d = vblnk_rise ? IDLE : PENDING;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: next values of the active and pending position registers
  always_comb begin
    ax_d = ax_q;
    ay_d = ay_q;
    px_d = px_q;
    py_d = py_q;
`ifdef SPRITE_MIRROR_EN
    mir_d  = mir_q;
    pmir_d = pmir_q;
`endif
    if (pos_valid && vblnk_rise) begin
      ax_d = xpos;
      ay_d = ypos;
`ifdef SPRITE_MIRROR_EN
      mir_d = mirror;
`endif
    end else if (vblnk_rise && (state_q == PENDING)) begin
      ax_d = px_q;
      ay_d = py_q;
`ifdef SPRITE_MIRROR_EN
      mir_d = pmir_q;
`endif
    end else if (pos_valid) begin
      px_d = xpos;
      py_d = ypos;
`ifdef SPRITE_MIRROR_EN
      pmir_d = mirror;
`endif
    end else begin
      px_d = px_q;
    end
  end

  // Position registers and vblank edge detector
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ax_q    <= 11'(INIT_X);
      ay_q    <= 11'(INIT_Y);
      px_q    <= 11'(INIT_X);
      py_q    <= 11'(INIT_Y);
      vblnk_q <= 1'b0;
`ifdef SPRITE_MIRROR_EN
      mir_q   <= 1'b0;
      pmir_q  <= 1'b0;
`endif
    end else begin
      ax_q    <= ax_d;
      ay_q    <= ay_d;
      px_q    <= px_d;
      py_q    <= py_d;
      vblnk_q <= vga_in.vblnk;
`ifdef SPRITE_MIRROR_EN
      mir_q   <= mir_d;
      pmir_q  <= pmir_d;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: hit test and ROM address
  // ---------------------------------------------------------------------------
  logic          hit_s;
  pos_t          hoff, voff, col;
  logic [AW-1:0] addr_s;
  logic [AW-1:0] rom_addr_q, rom_addr_d;
  logic          hit_q;
  logic          blank1_q;
  logic [11:0]   rgb1_q;

  assign hit_s = in_span(vga_in.hcount, ax_q, WIDTH) &&
                 in_span(vga_in.vcount, ay_q, HEIGHT);

  // Offsets are only meaningful when hit_s is set, so 11-bit wrap is harmless.
  assign hoff = vga_in.hcount - ax_q;
  assign voff = vga_in.vcount - ay_q;

`ifdef SPRITE_MIRROR_EN
  assign col = mir_q ? (11'(WIDTH - 1) - hoff) : hoff;
`else
  assign col = hoff;
`endif

  assign addr_s = AW'(32'(voff) * 32'(WIDTH) + 32'(col));

  // Address holds outside the sprite to avoid needless ROM toggling
  always_comb begin
    if (hit_s) begin
      rom_addr_d = addr_s;
    end else begin
      rom_addr_d = rom_addr_q;
    end
  end

  // Stage 1 registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rom_addr_q <= '0;
      hit_q      <= 1'b0;
      blank1_q   <= 1'b0;
      rgb1_q     <= 12'h000;
    end else begin
      rom_addr_q <= rom_addr_d;
      hit_q      <= hit_s;
      blank1_q   <= vga_in.hblnk | vga_in.vblnk;
      rgb1_q     <= vga_in.rgb;
    end
  end

  assign rom_addr = rom_addr_q;

  // ---------------------------------------------------------------------------
  // Stage 2: colour select (blank > opaque sprite pixel > background)
  // ---------------------------------------------------------------------------
  logic [11:0] rgb_out_q, rgb_out_d;

  always_comb begin
    if (blank1_q) begin
      rgb_out_d = 12'h000;
    end else if (hit_q && (rom_pixel != KEY_COLOR)) begin
      rgb_out_d = rom_pixel;
    end else begin
      rgb_out_d = rgb1_q;
    end
  end

  // Stage 2 register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rgb_out_q <= 12'h000;
    end else begin
      rgb_out_q <= rgb_out_d;
    end
  end

  assign vga_out.hcount = tim_out.hcount;
  assign vga_out.vcount = tim_out.vcount;
  assign vga_out.hsync  = tim_out.hsync;
  assign vga_out.vsync  = tim_out.vsync;
  assign vga_out.hblnk  = tim_out.hblnk;
  assign vga_out.vblnk  = tim_out.vblnk;
  assign vga_out.rgb    = rgb_out_q;

endmodule

// File: tb/tb_draw_sprite.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_draw_sprite
// Scoreboard bench for draw_sprite: every driven pixel pushes its expected
// output bundle; the entry is popped and compared when the pipeline delivers it.
// The ROM model returns addr[11:0], except address 5 which holds the key colour.
// -----------------------------------------------------------------------------
module tb_draw_sprite;
  import vga_pkg::*;

  localparam int          W   = 64;
  localparam int          H   = 64;
  localparam logic [11:0] KEY = 12'hF0F;

  typedef struct packed {
    logic [25:0] tim;
    logic [11:0] rgb;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] xpos;
  logic [10:0] ypos;
  logic        pos_valid;
  logic [11:0] rom_addr;
  logic [11:0] rom_pixel;
`ifdef SPRITE_MIRROR_EN
  logic        mirror;
`endif

  vga_if vin ();
  vga_if vout ();

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];

  // reference position model
  int ex, ey, pxm, pym;
  bit pend, prev_vb, emir, pmir;

  always #5 clk = ~clk;

  function automatic logic [11:0] rom_fn(input logic [11:0] a);
    return (a == 12'd5) ? KEY : a;
  endfunction

  // ROM data for the registered address, available before the next edge
  assign rom_pixel = rom_fn(rom_addr);

  draw_sprite dut (
    .clk       (clk),
    .rst       (rst),
    .vga_in    (vin),
    .vga_out   (vout),
    .xpos      (xpos),
    .ypos      (ypos),
    .pos_valid (pos_valid),
`ifdef SPRITE_MIRROR_EN
    .mirror    (mirror),
`endif
    .rom_addr  (rom_addr),
    .rom_pixel (rom_pixel)
  );

  task automatic check_eq(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] out_tim();
    return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
  endfunction

  function automatic logic [11:0] exp_rgb(input int h, input int v, input logic [11:0] bg, input bit blank);
    int col, row;
    logic [11:0] a, p;
    if (blank) return 12'h000;
    if (h >= ex && h < ex + W && v >= ey && v < ey + H) begin
      col = h - ex;
      if (emir) col = W - 1 - col;
      row = v - ey;
      a = 12'(row * W + col);
      p = rom_fn(a);
      if (p != KEY) return p;
    end
    return bg;
  endfunction

  // Drive one pixel, queue its expectation, advance one clock, compare the
  // entry that has just emerged from the 2-cycle pipeline.
  task automatic step(input int h, input int v, input logic [11:0] rgb,
                      input bit pv, input int x, input int y, input bit m);
    logic hb, vb, hs, vs;
    exp_t e;
    hb = (h >= H_ACTIVE);
    vb = (v >= V_ACTIVE);
    hs = (h >= 1048 && h < 1184);
    vs = (v >= 771 && v < 777);
    vin.hcount = 11'(h);
    vin.vcount = 11'(v);
    vin.hsync  = hs;
    vin.vsync  = vs;
    vin.hblnk  = hb;
    vin.vblnk  = vb;
    vin.rgb    = rgb;
    pos_valid  = pv;
    xpos       = 11'(x);
    ypos       = 11'(y);
`ifdef SPRITE_MIRROR_EN
    mirror     = m;
`endif
    e.tim = {11'(h), 11'(v), hs, vs, hb, vb};
    e.rgb = exp_rgb(h, v, rgb, hb | vb);
    sb.push_back(e);
    if (pv && vb && !prev_vb) begin
      ex = x; ey = y; emir = m; pend = 1'b0;
    end else if (vb && !prev_vb && pend) begin
      ex = pxm; ey = pym; emir = pmir; pend = 1'b0;
    end else if (pv) begin
      pxm = x; pym = y; pmir = m; pend = 1'b1;
    end
    prev_vb = vb;
    @(posedge clk);
    #1;
    pos_valid = 1'b0;
    if (sb.size() == 2) begin
      e = sb.pop_front();
      check_eq($sformatf("tim@%0d,%0d", e.tim[25:15], e.tim[14:4]), {14'd0, out_tim()}, {14'd0, e.tim});
      check_eq($sformatf("rgb@%0d,%0d", e.tim[25:15], e.tim[14:4]), {28'd0, vout.rgb}, {28'd0, e.rgb});
    end
  endtask

  task automatic px(input int h, input int v);
    step(h, v, 12'h123, 1'b0, 0, 0, 1'b0);
  endtask

  task automatic pv(input int h, input int v, input int x, input int y, input bit m);
    step(h, v, 12'h123, 1'b1, x, y, m);
  endtask

  task automatic model_reset();
    sb.delete();
    ex = 0; ey = 0; pxm = 0; pym = 0;
    pend = 1'b0; prev_vb = 1'b0; emir = 1'b0; pmir = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    pos_valid = 1'b0;
    xpos = 11'd0;
    ypos = 11'd0;
`ifdef SPRITE_MIRROR_EN
    mirror = 1'b0;
`endif
    vin.hcount = 11'd0; vin.vcount = 11'd0;
    vin.hsync = 1'b0; vin.vsync = 1'b0; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
    vin.rgb = 12'h123;
    model_reset();

    // reset state
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_tim", {14'd0, out_tim()}, 40'd0);
    check_eq("reset_rgb", {28'd0, vout.rgb}, 40'd0);
    check_eq("reset_rom_addr", {28'd0, rom_addr}, 40'd0);
    rst = 1'b0;

    // sprite parked off-screen: background and blanking only
    pv(0, 770, 2000, 2000, 1'b0);
    for (int h = 0; h < 6; h++) px(h, 10);
    px(1023, 10); px(1024, 10); px(1100, 10);
    px(500, 767); px(500, 768); px(500, 774);

    // placement at (100,50)
    px(0, 0); pv(0, 770, 100, 50, 1'b0);
    px(100, 50); px(163, 113); px(164, 50);
    check_eq("rom_addr_hold", {28'd0, rom_addr}, 40'd4095);
    px(99, 50); px(105, 50); px(104, 50); px(106, 50); px(100, 114); px(100, 49);

    // deferred update, last request wins
    pv(0, 400, 300, 200, 1'b0);
    px(100, 50); px(300, 200);
    pv(0, 500, 10, 10, 1'b0);
    px(100, 50); px(0, 770);
    px(10, 10); px(100, 50); px(300, 200); px(73, 73);

    // request while vblank already high waits for the next rise
    px(0, 769); pv(0, 771, 1000, 740, 1'b0);
    px(10, 10); px(0, 770);

    // edge clip at (1000,740)
    px(1000, 740); px(1023, 767); px(1024, 740); px(0, 740); px(999, 740); px(1010, 739);

    // position near 2047: 12-bit compares, no wrap to low columns
    px(0, 0); pv(0, 770, 2040, 5, 1'b0);
    px(2045, 5);
    check_eq("rom_addr_2045", {28'd0, rom_addr}, 40'd5);
    px(3, 5);
    check_eq("rom_addr_nowrap", {28'd0, rom_addr}, 40'd5);
    px(2047, 68);
    check_eq("rom_addr_2047_68", {28'd0, rom_addr}, 40'd4039);

`ifdef SPRITE_MIRROR_EN
    // mirror applied at vblank, mid-frame toggle deferred
    px(0, 0); pv(0, 770, 100, 50, 1'b1);
    px(100, 50);
    check_eq("rom_addr_mirror", {28'd0, rom_addr}, 40'd63);
    pv(0, 100, 100, 50, 1'b0);
    px(100, 50); px(101, 50);
    px(0, 770); px(100, 50); px(163, 50);
`endif

    // reset mid-frame: outputs clear at once, resume after 2 clocks at INIT pos
    px(1000, 740); px(1001, 740);
    #2 rst = 1'b1;
    #1;
    check_eq("midrst_tim", {14'd0, out_tim()}, 40'd0);
    check_eq("midrst_rgb", {28'd0, vout.rgb}, 40'd0);
    check_eq("midrst_rom_addr", {28'd0, rom_addr}, 40'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    px(0, 0); px(64, 0); px(63, 63); px(5, 0); px(6, 0);

    // flush
    px(0, 0); px(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
